// File: rtl/tinyalu_core.sv
// tinyalu_core: responder side of the TinyALU start/done handshake.
// Single-cycle add/and/xor, multi-cycle multiply (MUL_LATENCY edges, 1..8),
// one-cycle done pulse with a registered, held result.
// Optional feature macro: TINYALU_ILLEGAL_OP_ERR_EN adds an illegal_op pulse
// output and makes opcodes 5/6 complete with result 0 instead of being ignored.
module tinyalu_core #(
  parameter int WIDTH       = 9,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
  ,
  output logic                 illegal_op
`endif
);

  localparam int RW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  // Counter covers MUL_LATENCY-1 for latencies up to 8.
  localparam logic [2:0] CNT_LOAD = 3'(MUL_LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [RW-1:0]    result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    alu_res;
  logic [RW-1:0]    mul_res;

  assign a_ext   = RW'(a_q);
  assign b_ext   = RW'(b_q);
  assign mul_res = a_ext * b_ext;

  // Single-cycle datapath on the latched operands; unknown opcodes give 0.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      default: alu_res = '0;
    endcase
  end

  // Handshake FSM: accept in IDLE, execute or count down, then wait for start to drop.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = result_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_AND, OP_XOR: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              state_d = EXEC;
            end
            OP_MUL: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              cnt_d   = CNT_LOAD;
              state_d = MUL;
            end
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            3'd5, 3'd6: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              state_d = EXEC;
            end
`endif
            default: ;
          endcase
        end
      end
      EXEC: begin
        done_d    = 1'b1;
        result_d  = alu_res;
        illegal_d = (op_q == 3'd5) || (op_q == 3'd6);
        state_d   = HOLD;
      end
      MUL: begin
        if (cnt_q == 3'd0) begin
          done_d   = 1'b1;
          result_d = mul_res;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and abandons any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

`ifdef TINYALU_ILLEGAL_OP_ERR_EN
  assign illegal_op = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: directed checks of the TinyALU handshake, datapath and reset.
module tb_tinyalu_core;

  logic        clk;
  logic        reset_n;
  logic [8:0]  A;
  logic [8:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [17:0] result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
  logic        illegal_op;
`endif

  int total;
  int bad;

  tinyalu_core #(.WIDTH(9), .MUL_LATENCY(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result)
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, hold start until done (bounded), then hold_extra more
  // cycles, then drop start for one cycle. lat counts edges from just before
  // acceptance to the edge after which done was seen (-1 on timeout).
  task automatic do_op(input logic [8:0] a, input logic [8:0] b, input logic [2:0] o,
                       input int hold_extra, output int lat, output logic [17:0] res,
                       output int extra_dones);
    A = a; B = b; op = o; start = 1'b1;
    lat = -1;
    res = 'x;
    extra_dones = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done === 1'b1) begin
        lat = i;
        res = result;
        break;
      end
    end
    for (int i = 0; i < hold_extra; i++) begin
      step();
      if (done !== 1'b0) extra_dones++;
    end
    start = 1'b0;
    step();
    if (done !== 1'b0) extra_dones++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
    #12;
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done actual=%b required=0", done); end
    total++;
    if (result !== 18'h0) begin bad++; $display("[TB] FAIL reset_result actual=%h required=00000", result); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int lat; logic [17:0] res; int extra;
    do_op(9'h1FF, 9'h001, 3'd1, 3, lat, res, extra);
    total++;
    if (lat !== 2) begin bad++; $display("[TB] FAIL add_latency actual=%0d required=2", lat); end
    total++;
    if (res !== 18'h00200) begin bad++; $display("[TB] FAIL add_result actual=%h required=00200", res); end
    total++;
    if (extra !== 0) begin bad++; $display("[TB] FAIL add_no_retrigger actual=%0d required=0", extra); end
    total++;
    if (result !== 18'h00200) begin bad++; $display("[TB] FAIL add_result_held actual=%h required=00200", result); end
  endtask

  task automatic test_logic();
    int lat; logic [17:0] res; int extra;
    do_op(9'h0F3, 9'h1A5, 3'd2, 0, lat, res, extra);
    total++;
    if (lat !== 2 || res !== 18'h000A1) begin
      bad++; $display("[TB] FAIL and_op actual=lat %0d res %h required=lat 2 res 000a1", lat, res);
    end
    do_op(9'h0F3, 9'h1A5, 3'd3, 0, lat, res, extra);
    total++;
    if (lat !== 2 || res !== 18'h00156) begin
      bad++; $display("[TB] FAIL xor_op actual=lat %0d res %h required=lat 2 res 00156", lat, res);
    end
  endtask

  task automatic test_mul();
    int lat;
    A = 9'h1FF; B = 9'h1FF; op = 3'd4; start = 1'b1;
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL mul_early_done actual=%b required=0", done); end
    A = '0; B = '0; op = 3'd0;
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      step();
      if (done === 1'b1) begin lat = i; break; end
    end
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL mul_latency actual=%0d required=4", lat); end
    total++;
    if (result !== 18'h3FC01) begin bad++; $display("[TB] FAIL mul_result actual=%h required=3fc01", result); end
    start = 1'b0;
    step();
    total++;
    if (done !== 1'b0 || result !== 18'h3FC01) begin
      bad++; $display("[TB] FAIL mul_after actual=done %b res %h required=done 0 res 3fc01", done, result);
    end
    step();
  endtask

  task automatic test_noop();
    int dones;
    dones = 0;
    A = 9'h055; B = 9'h0AA; op = 3'd0; start = 1'b1;
    step();
    if (done !== 1'b0) dones++;
    op = 3'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0) dones++;
    end
    start = 1'b0;
    step();
    total++;
    if (dones !== 0) begin bad++; $display("[TB] FAIL noop_done actual=%0d required=0", dones); end
    total++;
    if (result !== 18'h3FC01) begin bad++; $display("[TB] FAIL noop_result actual=%h required=3fc01", result); end
  endtask

  task automatic test_reset_mid_mul();
    int lat; logic [17:0] res; int extra; int dones;
    A = 9'h003; B = 9'h005; op = 3'd4; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5;
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || result !== 18'h0) begin
      bad++; $display("[TB] FAIL reset_mid_mul actual=done %b res %h required=done 0 res 00000", done, result);
    end
    #19;
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("[TB] FAIL reset_no_done actual=%0d required=0", dones); end
    do_op(9'h002, 9'h003, 3'd1, 0, lat, res, extra);
    total++;
    if (lat !== 2 || res !== 18'h00005) begin
      bad++; $display("[TB] FAIL add_after_reset actual=lat %0d res %h required=lat 2 res 00005", lat, res);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [17:0] res; int extra;
    do_op(9'h100, 9'h100, 3'd1, 0, lat, res, extra);
    total++;
    if (lat !== 2 || res !== 18'h00200) begin
      bad++; $display("[TB] FAIL b2b_first actual=lat %0d res %h required=lat 2 res 00200", lat, res);
    end
    do_op(9'h00C, 9'h00D, 3'd4, 0, lat, res, extra);
    total++;
    if (lat !== 4 || res !== 18'h0009C) begin
      bad++; $display("[TB] FAIL b2b_mul actual=lat %0d res %h required=lat 4 res 0009c", lat, res);
    end
  endtask

  task automatic test_illegal_op();
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    int lat; logic ill; logic [17:0] res;
    A = 9'h0FF; B = 9'h0FF; op = 3'd5; start = 1'b1;
    lat = -1; ill = 1'b0; res = 'x;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done === 1'b1) begin lat = i; ill = illegal_op; res = result; break; end
    end
    total++;
    if (lat !== 2 || ill !== 1'b1 || res !== 18'h0) begin
      bad++; $display("[TB] FAIL illegal_op actual=lat %0d ill %b res %h required=lat 2 ill 1 res 00000", lat, ill, res);
    end
    start = 1'b0;
    step();
    total++;
    if (illegal_op !== 1'b0) begin bad++; $display("[TB] FAIL illegal_pulse actual=%b required=0", illegal_op); end
    step();
`else
    int dones;
    dones = 0;
    A = 9'h0FF; B = 9'h0FF; op = 3'd5; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 1'b0) dones++;
    end
    start = 1'b0;
    step();
    total++;
    if (dones !== 0) begin bad++; $display("[TB] FAIL op5_ignored actual=%0d required=0", dones); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_logic();
    test_mul();
    test_noop();
    test_reset_mid_mul();
    test_back_to_back();
    test_illegal_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
